// File: rtl/sa_act_feeder_pkg.sv
// Shared types and helpers for the systolic-array activation feeder.
//   feeder_state_t : job sequencing states (IDLE, STREAM, DRAIN, DONE)
//   drain_cycles() : cycles needed after the last accepted vector until the
//                    final partial sums have left a ROWS x COLS array
package sa_act_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_t;

  // The last vector needs ROWS-1 cycles to finish skewing into the bottom row,
  // then COLS cycles to ripple across the array.
  function automatic int drain_cycles(input int rows, input int cols);
    return rows - 1 + cols;
  endfunction

endpackage

// File: rtl/sa_act_feeder_if.sv
// Upstream activation-vector stream into the feeder (valid/ready handshake).
//   i_act_valid : upstream has a vector this cycle
//   o_act_ready : feeder accepts a vector this cycle
//   i_act       : vector, row r element at bits [r*MUL_DATAWIDTH +: MUL_DATAWIDTH]
// Signal names carry the feeder's point of view (i_ = into the feeder).
interface sa_act_feeder_if #(
  parameter int ROWS          = 4,
  parameter int MUL_DATAWIDTH = 8
);

  logic                          i_act_valid;
  logic                          o_act_ready;
  logic [ROWS*MUL_DATAWIDTH-1:0] i_act;

  // Upstream producer side.
  modport master (
    output i_act_valid,
    output i_act,
    input  o_act_ready
  );

  // Feeder side.
  modport slave (
    input  i_act_valid,
    input  i_act,
    output o_act_ready
  );

endinterface

// File: rtl/sa_skew_line.sv
// One row's delay line: DEPTH-stage shift register of {valid, data}.
//   clk, rst_n : clock, asynchronous active-low clear of every stage
//   in_valid   : tag for the element entering this cycle
//   in_data    : element entering this cycle
//   out_valid  : tag of the element leaving the last stage
//   out_data   : element leaving the last stage (DEPTH cycles after entry)
module sa_skew_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] valid_q;
  logic [W-1:0]     data_q [DEPTH];

  // NOTE: every stage of this storage array is reset, not just the tags; the
  // array must see zeros (not stale operands) right after a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/sa_act_feeder.sv
// Activation feeder for the left edge of a ROWS x COLS systolic PE array.
// Accepts one vector per cycle, skews it so row r lags row 0 by r cycles,
// and sequences STREAM -> DRAIN -> DONE with the array mode signal.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_start     : start a job (honoured only in IDLE)
//   i_num_vec   : vectors in the job, sampled with i_start (0..MAX_VEC)
//   act_if      : upstream vector stream (slave side)
//   o_act       : skewed activations, row r at [r*W +: W]
//   o_row_valid : per-row tag, o_act row r carries real data
//   o_mode      : 0 preload, 1 compute; aligned with o_act
//   o_busy      : job in progress
//   o_done      : one-cycle job-complete pulse
module sa_act_feeder
  import sa_act_feeder_pkg::*;
#(
  parameter  int MUL_DATAWIDTH = 8,
  parameter  int ROWS          = 4,
  parameter  int COLS          = 4,
  parameter  int MAX_VEC       = 256,
  localparam int VEC_W         = $clog2(MAX_VEC + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_start,
  input  logic [VEC_W-1:0]              i_num_vec,
  sa_act_feeder_if.slave                act_if,
  output logic [ROWS*MUL_DATAWIDTH-1:0] o_act,
  output logic [ROWS-1:0]               o_row_valid,
  output logic                          o_mode,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int DRAIN_CYCLES = drain_cycles(ROWS, COLS);
  localparam int DRAIN_W      = $clog2(DRAIN_CYCLES + 1);

  feeder_state_t      state;
  logic [VEC_W-1:0]   num_vec;
  logic [VEC_W-1:0]   vec_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               hs;

  assign act_if.o_act_ready = (state == STREAM);
  assign hs                 = act_if.i_act_valid && act_if.o_act_ready;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge value of the others, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      num_vec   <= '0;
      vec_cnt   <= '0;
      drain_cnt <= '0;
      o_mode    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      // Follows the state one cycle late, like the data that entered the
      // skew lines in that state, so mode and data reach the array together.
      o_mode <= (state == STREAM) || (state == DRAIN);

      unique case (state)
        IDLE: begin
          if (i_start) begin
            num_vec   <= i_num_vec;
            vec_cnt   <= '0;
            drain_cnt <= '0;
            o_busy    <= 1'b1;
            if (i_num_vec == '0) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state <= STREAM;
            end
          end
        end

        STREAM: begin
          if (hs) begin
            vec_cnt <= vec_cnt + 1'b1;
            if (vec_cnt + 1'b1 == num_vec) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end
        end

        DRAIN: begin
          if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
            state  <= DONE;
            o_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Row r gets r+1 registers. Cycles without a handshake push a zero element
  // tagged invalid, so bubbles add nothing to the partial sums.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [MUL_DATAWIDTH-1:0] row_in;

    assign row_in = hs ? act_if.i_act[r*MUL_DATAWIDTH +: MUL_DATAWIDTH] : '0;

    sa_skew_line #(
      .DEPTH (r + 1),
      .W     (MUL_DATAWIDTH)
    ) u_skew (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (hs),
      .in_data   (row_in),
      .out_valid (o_row_valid[r]),
      .out_data  (o_act[r*MUL_DATAWIDTH +: MUL_DATAWIDTH])
    );
  end

  a_num_vec_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (state == IDLE && i_start) |-> (i_num_vec <= VEC_W'(MAX_VEC)));

endmodule
